// File: rtl/pix_pkg.sv
// Shared constants and state type for the 12-bit to 16-bit pixel word packer.
package pix_pkg;

  localparam int PixWidth  = 12;  // sensor pixel width
  localparam int WordWidth = 16;  // RAM write word width
  localparam int AccWidth  = 32;  // accumulator holds up to two words of bits
  localparam int BitsWidth = 6;   // fill level 0..32 plus headroom for +12

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CAPTURE,
    FLUSH
  } pix_pack_state_t;

endpackage

// File: rtl/pix_bit_accumulator.sv
// Bit accumulator: appends pixels LSB-first, emits 16-bit words through a
// valid/ready output register, and zero-pads a partial word on request.
module pix_bit_accumulator
  import pix_pkg::*;
(
  input  logic                 pix_clk,
  input  logic                 pix_rst,
  input  logic                 i_push,      // pixel presented this cycle
  input  logic [PixWidth-1:0]  i_pix,
  input  logic                 i_pad,       // flushing: round a partial word up to 16 bits
  input  logic                 i_wr_ready,
  output logic                 o_can_push,  // room for a pixel this cycle
  output logic                 o_empty,     // no bits left in the accumulator
  output logic [WordWidth-1:0] o_wr_data,
  output logic                 o_wr_valid
);

  logic [AccWidth-1:0]  r_acc;
  logic [BitsWidth-1:0] r_acc_bits;
  logic [WordWidth-1:0] r_wr_data;
  logic                 r_wr_valid;

  logic                 w_pop;
  logic                 w_do_push;
  logic                 w_pad_now;
  logic [BitsWidth-1:0] w_bits_after;
  logic [AccWidth-1:0]  w_acc_shift;

  // A word leaves when one is complete and the output register is free or draining.
  assign w_pop        = (r_acc_bits >= BitsWidth'(WordWidth)) && (!r_wr_valid || i_wr_ready);
  assign w_bits_after = r_acc_bits - (w_pop ? BitsWidth'(WordWidth) : '0);
  assign w_acc_shift  = w_pop ? (r_acc >> WordWidth) : r_acc;
  assign o_can_push   = (w_bits_after + BitsWidth'(PixWidth)) <= BitsWidth'(AccWidth);
  assign w_do_push    = i_push && o_can_push;
  // Bits above the fill level are always zero, so padding is just raising the level.
  assign w_pad_now    = i_pad && (r_acc_bits != '0) && (r_acc_bits < BitsWidth'(WordWidth));

  // Accumulator: pop and push can happen together, push lands above the remaining bits.
  always_ff @(posedge pix_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (pix_rst) begin
      r_acc      <= '0;
      r_acc_bits <= '0;
    end else if (w_do_push) begin
      r_acc      <= w_acc_shift | (AccWidth'(i_pix) << w_bits_after);
      r_acc_bits <= w_bits_after + BitsWidth'(PixWidth);
    end else if (w_pad_now) begin
      r_acc_bits <= BitsWidth'(WordWidth);
    end else begin
      r_acc      <= w_acc_shift;
      r_acc_bits <= w_bits_after;
    end
  end

  // Output register: loads on pop, holds until accepted, clears on accept.
  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      r_wr_data  <= '0;
      r_wr_valid <= 1'b0;
    end else if (w_pop) begin
      r_wr_data  <= r_acc[WordWidth-1:0];
      r_wr_valid <= 1'b1;
    end else if (r_wr_valid && i_wr_ready) begin
      r_wr_data  <= '0;
      r_wr_valid <= 1'b0;
    end
  end

  assign o_empty    = (r_acc_bits == '0);
  assign o_wr_data  = r_wr_data;
  assign o_wr_valid = r_wr_valid;

endmodule

// File: rtl/pix_word_packer.sv
// Frame-level control for the pixel packer: arm/capture/flush FSM, frame-valid
// edge detection, pixel counter and sticky overflow.
module pix_word_packer
  import pix_pkg::*;
#(
  parameter int PixCountWidth = 21
) (
  input  logic                     pix_clk,
  input  logic                     pix_rst,
  input  logic                     capture,
  input  logic                     pix_frameValid,
  input  logic [PixWidth-1:0]      pix_d,
  input  logic                     pix_dValid,
  output logic [WordWidth-1:0]     wr_data,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic [PixCountWidth-1:0] pix_count,
  output logic                     overflow,
  output logic                     done,
  output logic                     busy
);

  pix_pack_state_t r_state;
  pix_pack_state_t w_state_next;
  logic            r_fv_prev;
  logic [PixCountWidth-1:0] r_pix_count;
  logic            r_overflow;

  logic w_start;
  logic w_present;
  logic w_can_push;
  logic w_empty;
  logic w_done;

  // Only a fresh rising edge starts capture, so a frame already running is skipped.
  assign w_start   = (r_state == ARMED) && pix_frameValid && !r_fv_prev;
  assign w_present = (r_state == CAPTURE) && pix_frameValid && pix_dValid;

  pix_bit_accumulator u_acc (
    .pix_clk    (pix_clk),
    .pix_rst    (pix_rst),
    .i_push     (w_present),
    .i_pix      (pix_d),
    .i_pad      (r_state == FLUSH),
    .i_wr_ready (wr_ready),
    .o_can_push (w_can_push),
    .o_empty    (w_empty),
    .o_wr_data  (wr_data),
    .o_wr_valid (wr_valid)
  );

  // State register and frame-valid history.
  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      r_state   <= IDLE;
      r_fv_prev <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_fv_prev <= pix_frameValid;
    end
  end

  // Next-state and done decode.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    w_state_next = r_state;
    w_done       = 1'b0;
    case (r_state)
      IDLE:    if (capture)         w_state_next = ARMED;
      ARMED:   if (w_start)         w_state_next = CAPTURE;
      CAPTURE: if (!pix_frameValid) w_state_next = FLUSH;
      FLUSH: begin
        if (w_empty && !wr_valid) begin
          w_state_next = IDLE;
          w_done       = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Per-frame statistics: cleared on capture start, saturating count, sticky drop flag.
  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      r_pix_count <= '0;
      r_overflow  <= 1'b0;
    end else if (w_start) begin
      r_pix_count <= '0;
      r_overflow  <= 1'b0;
    end else if (w_present) begin
      if (!w_can_push) begin
        r_overflow <= 1'b1;
      end else if (r_pix_count != '1) begin
        r_pix_count <= r_pix_count + PixCountWidth'(1);
      end
    end
  end

  assign pix_count = r_pix_count;
  assign overflow  = r_overflow;
  assign done      = w_done;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_pix_word_packer.sv
// Self-checking bench for pix_word_packer: directed scenarios plus random frames
// compared against a bitstream-level packing model.
module tb_pix_word_packer;

  logic        pix_clk;
  logic        pix_rst;
  logic        capture;
  logic        pix_frameValid;
  logic [11:0] pix_d;
  logic        pix_dValid;
  logic [15:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [20:0] pix_count;
  logic        overflow;
  logic        done;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  int done_base;

  logic [11:0] pix_q[$];   // pixels the bench expects to be packed
  logic [15:0] exp_q[$];   // model output words
  logic [15:0] got_q[$];   // words accepted from the DUT

  logic        prev_hold;
  logic [15:0] prev_data;

  pix_word_packer dut (
    .pix_clk        (pix_clk),
    .pix_rst        (pix_rst),
    .capture        (capture),
    .pix_frameValid (pix_frameValid),
    .pix_d          (pix_d),
    .pix_dValid     (pix_dValid),
    .wr_data        (wr_data),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .pix_count      (pix_count),
    .overflow       (overflow),
    .done           (done),
    .busy           (busy)
  );

  initial pix_clk = 1'b0;
  always #5 pix_clk = ~pix_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor on the falling edge: record handshakes, done pulses, and hold stability.
  always @(negedge pix_clk) begin
    if (pix_rst) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", wr_valid, 1'b1);
        check("hold_data", wr_data, prev_data);
      end
      if (wr_valid && wr_ready) got_q.push_back(wr_data);
      if (done) begin
        done_cnt++;
        check("done_after_drain", wr_valid, 1'b0);
      end
      prev_hold = wr_valid && !wr_ready;
      prev_data = wr_data;
    end
  end

  // Reference: concatenate pixel bits LSB-first, zero-pad to a word boundary, slice.
  function automatic void build_expected();
    logic bitq[$];
    logic [11:0] p;
    logic [15:0] w;
    exp_q.delete();
    foreach (pix_q[i]) begin
      p = pix_q[i];
      for (int b = 0; b < 12; b++) bitq.push_back(p[b]);
    end
    while ((bitq.size() % 16) != 0) bitq.push_back(1'b0);
    for (int k = 0; k < bitq.size() / 16; k++) begin
      for (int b = 0; b < 16; b++) w[b] = bitq[k*16 + b];
      exp_q.push_back(w);
    end
  endfunction

  task automatic tick();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic start_test();
    got_q.delete();
    pix_q.delete();
    done_base = done_cnt;
  endtask

  task automatic arm();
    capture = 1'b1;
    tick();
    capture = 1'b0;
  endtask

  task automatic frame_rise();
    pix_frameValid = 1'b1;
    tick();
  endtask

  task automatic send_all();
    foreach (pix_q[i]) begin
      pix_d      = pix_q[i];
      pix_dValid = 1'b1;
      tick();
    end
    pix_dValid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input bit rand_ready);
    int n = 0;
    while (busy && n < max_cycles) begin
      if (rand_ready) wr_ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    wr_ready = 1'b1;
    check("idle_within_bound", busy, 1'b0);
  endtask

  task automatic compare_words(input string tag);
    build_expected();
    check({tag, "_word_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, "_word"}, got_q[i], exp_q[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int ncyc;
    pix_rst = 1'b1; capture = 1'b0; pix_frameValid = 1'b0;
    pix_d = '0; pix_dValid = 1'b0; wr_ready = 1'b1;
    prev_hold = 1'b0; prev_data = '0;
    tick(); tick();
    pix_rst = 1'b0;
    tick();

    // Reset state
    check("rst_wr_valid", wr_valid, 1'b0);
    check("rst_wr_data", wr_data, 16'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pix_count", pix_count, 21'd0);
    check("rst_overflow", overflow, 1'b0);

    // Pack order
    start_test();
    arm();
    check("armed_busy", busy, 1'b1);
    frame_rise();
    pix_q = '{12'h123, 12'h456, 12'h789, 12'hABC};
    send_all();
    pix_frameValid = 1'b0;
    wait_idle(40, 1'b0);
    compare_words("pack");
    if (got_q.size() > 0) check("pack_first_literal", got_q[0], 16'h6123);
    check("pack_pix_count", pix_count, 21'd4);
    check("pack_overflow", overflow, 1'b0);
    check("pack_done_pulses", done_cnt - done_base, 1);

    // Flush / pad
    start_test();
    arm();
    frame_rise();
    pix_q = '{12'hFFF};
    send_all();
    pix_frameValid = 1'b0;
    wait_idle(40, 1'b0);
    compare_words("pad");
    if (got_q.size() > 0) check("pad_literal", got_q[0], 16'h0FFF);
    check("pad_pix_count", pix_count, 21'd1);
    check("pad_done_pulses", done_cnt - done_base, 1);

    // Backpressure: fifth pixel has no room
    start_test();
    wr_ready = 1'b0;
    arm();
    frame_rise();
    pix_q = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h005};
    send_all();
    void'(pix_q.pop_back());
    check("bp_wr_valid", wr_valid, 1'b1);
    check("bp_first_word", wr_data, 16'h2001);
    check("bp_overflow", overflow, 1'b1);
    check("bp_pix_count", pix_count, 21'd4);
    tick(); tick(); tick();
    check("bp_word_held", wr_data, 16'h2001);
    check("bp_nothing_accepted", got_q.size(), 0);
    check("bp_no_early_done", done_cnt - done_base, 0);
    // Release
    wr_ready = 1'b1;
    pix_frameValid = 1'b0;
    wait_idle(40, 1'b0);
    compare_words("release");
    check("release_done_pulses", done_cnt - done_base, 1);

    // Arming: frame already running is skipped, capture while busy ignored
    start_test();
    pix_frameValid = 1'b1;
    tick();
    arm();
    pix_q = '{12'h111, 12'h222};
    send_all();
    check("skip_busy", busy, 1'b1);
    check("skip_no_words", got_q.size(), 0);
    check("skip_count_kept", pix_count, 21'd4);
    pix_frameValid = 1'b0;
    tick();
    check("skip_still_armed", busy, 1'b1);
    arm();
    frame_rise();
    pix_q.delete();
    for (int i = 0; i < 6; i++) pix_q.push_back(12'($urandom));
    send_all();
    arm();
    pix_frameValid = 1'b0;
    wait_idle(40, 1'b0);
    compare_words("arm");
    check("arm_pix_count", pix_count, 21'd6);
    check("arm_overflow_cleared", overflow, 1'b0);
    check("arm_done_pulses", done_cnt - done_base, 1);
    tick(); tick(); tick();
    check("arm_not_rearmed", busy, 1'b0);

    // Reset mid-capture with a word held
    start_test();
    wr_ready = 1'b0;
    arm();
    frame_rise();
    pix_q = '{12'hA5A, 12'h5A5, 12'h3C3};
    send_all();
    check("rstmid_pre_valid", wr_valid, 1'b1);
    pix_rst = 1'b1;
    pix_frameValid = 1'b0;
    tick();
    pix_rst = 1'b0;
    wr_ready = 1'b1;
    check("rstmid_wr_valid", wr_valid, 1'b0);
    check("rstmid_busy", busy, 1'b0);
    check("rstmid_pix_count", pix_count, 21'd0);
    check("rstmid_overflow", overflow, 1'b0);
    tick(); tick();
    check("rstmid_no_done", done_cnt - done_base, 0);
    check("rstmid_no_words", got_q.size(), 0);

    // Random frames: full-rate ready while capturing, random ready while draining
    for (int f = 0; f < 10; f++) begin
      start_test();
      wr_ready = 1'b1;
      arm();
      frame_rise();
      ncyc = (f == 0) ? 0 : int'($urandom_range(1, 40));
      for (int c = 0; c < ncyc; c++) begin
        if ($urandom_range(0, 3) != 0) begin
          pix_d      = 12'($urandom);
          pix_dValid = 1'b1;
          pix_q.push_back(pix_d);
        end else begin
          pix_dValid = 1'b0;
        end
        tick();
      end
      pix_dValid     = 1'b0;
      pix_frameValid = 1'b0;
      wait_idle(400, 1'b1);
      compare_words("rand");
      check("rand_pix_count", pix_count, pix_q.size());
      check("rand_overflow", overflow, 1'b0);
      check("rand_done_pulses", done_cnt - done_base, 1);
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
